// File: rtl/acq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : acq_pkg                                                  |
// | Purpose  : Shared types and helpers for the capture readout         |
// |            sequencer: state encoding, channel geometry and          |
// |            channel-mask scan functions.                             |
// | Options  : ACQ_READOUT_CSUM_EN adds the checksum state.             |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package acq_pkg;

  localparam int CH_N   = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_RDY  = 3'd2,
    ST_FETCH     = 3'd3,
    ST_WAIT_DATA = 3'd4,
    ST_SEND      = 3'd5,
    ST_DONE      = 3'd6
`ifdef ACQ_READOUT_CSUM_EN
    ,ST_CSUM     = 3'd7
`endif
  } acq_state_t;

  // Index of the lowest enabled channel (0 when the mask is empty).
  function automatic logic [1:0] lowest_set(input logic [CH_N-1:0] mask);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = CH_N - 1; i >= 0; i--) begin
      if (mask[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // {found, index} of the first enabled channel strictly above cur.
  function automatic logic [2:0] next_set(input logic [CH_N-1:0] mask,
                                          input logic [1:0]      cur);
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < CH_N; i++) begin
      if (!found && (i > int'(cur)) && mask[i]) begin
        found = 1'b1;
        idx   = 2'(i);
      end
    end
    return {found, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/acq_rd_lat_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : acq_rd_lat_pipe                                          |
// | Purpose  : Delays the RAM read strobe by the RAM read latency so    |
// |            the sequencer knows the cycle in which rd_data is valid. |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module acq_rd_lat_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  input  logic i_vld,
  output logic o_vld
);

  generate
    if (RD_LAT <= 1) begin : g_lat1
      logic r_vld;
      // Single-stage marker for a one-cycle RAM.
      always_ff @(posedge clk) begin
        if (!rstn || i_clr) r_vld <= 1'b0;
        else                r_vld <= i_vld;
      end
      assign o_vld = r_vld;
    end else begin : g_latn
      logic [RD_LAT-1:0] r_sr;
      // Shift the strobe through RD_LAT stages; an abort drops in-flight marks.
      always_ff @(posedge clk) begin
        if (!rstn || i_clr) r_sr <= '0;
        else                r_sr <= {r_sr[RD_LAT-2:0], i_vld};
      end
      assign o_vld = r_sr[RD_LAT-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/acq_readout_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : acq_readout_seq                                          |
// | Purpose  : Arms one oscilloscope capture, waits for data_ready,     |
// |            then streams the pre-trigger window of the capture RAM   |
// |            (enabled channels only) over a valid/ready byte link.    |
// | Options  : ACQ_READOUT_CSUM_EN appends an XOR checksum byte.        |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module acq_readout_seq
  import acq_pkg::*;
#(
  parameter int RAM_W       = 10,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int HOLDOFF     = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_arm,
  input  logic             cmd_abort,
  input  logic [RAM_W-1:0] cfg_triggerpoint,
  input  logic [RAM_W:0]   cfg_nsamples,
  input  logic [3:0]       cfg_chmask,
  output logic             start_trigger,
  input  logic             data_ready,
  input  logic [RAM_W-1:0] wraddress_triggerpoint,
  output logic             rden,
  output logic [RAM_W-1:0] rdaddress,
  input  logic [31:0]      rd_data,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             timeout_err,
  output logic             cfg_err
);

  localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam int HO_W  = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [RAM_W:0] NS_MAX = {1'b1, {RAM_W{1'b0}}};

  acq_state_t        r_state;
  logic [RAM_W-1:0]  r_tp;
  logic [RAM_W:0]    r_ns;
  logic [3:0]        r_mask;
  logic [RAM_W-1:0]  r_addr;
  logic [RAM_W:0]    r_rem;
  logic [31:0]       r_hold;
  logic [1:0]        r_ch;
  logic [HO_W-1:0]   r_ho;
  logic [TMO_W-1:0]  r_tmo;
`ifdef ACQ_READOUT_CSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_rd_vld;
  logic              w_arm_ok;
  logic [RAM_W-1:0]  w_win_start;
  logic [RAM_W-1:0]  w_addr_inc;
  logic [RAM_W:0]    w_rem_dec;
  logic [1:0]        w_first;
  logic [2:0]        w_nxt;

  acq_rd_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_lat_pipe (
    .clk   (clk),
    .rstn  (rstn),
    .i_clr (cmd_abort),
    .i_vld (rden),
    .o_vld (w_rd_vld)
  );

  assign w_arm_ok    = (cfg_chmask != 4'd0) && (cfg_nsamples != '0) &&
                       (cfg_nsamples <= NS_MAX);
  assign w_win_start = wraddress_triggerpoint - r_tp;
  assign w_addr_inc  = r_addr + 1'b1;
  assign w_rem_dec   = r_rem - 1'b1;
  assign w_first     = lowest_set(r_mask);
  assign w_nxt       = next_set(r_mask, r_ch);
  assign busy        = (r_state != ST_IDLE);

  // Sequencer: state, shadow configuration, read addressing and stream outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_tp          <= '0;
      r_ns          <= '0;
      r_mask        <= '0;
      r_addr        <= '0;
      r_rem         <= '0;
      r_hold        <= '0;
      r_ch          <= '0;
      r_ho          <= '0;
      r_tmo         <= '0;
`ifdef ACQ_READOUT_CSUM_EN
      r_csum        <= '0;
`endif
      start_trigger <= 1'b0;
      rden          <= 1'b0;
      rdaddress     <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      frame_done    <= 1'b0;
      timeout_err   <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      start_trigger <= 1'b0;
      frame_done    <= 1'b0;
      cfg_err       <= 1'b0;
      if (cmd_abort) begin
        r_state   <= ST_IDLE;
        rden      <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (cmd_arm) begin
              if (w_arm_ok) begin
                r_tp          <= cfg_triggerpoint;
                r_ns          <= cfg_nsamples;
                r_mask        <= cfg_chmask;
                timeout_err   <= 1'b0;
                start_trigger <= 1'b1;
`ifdef ACQ_READOUT_CSUM_EN
                r_csum        <= '0;
`endif
                r_state       <= ST_ARM;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          ST_ARM: begin
            r_ho    <= '0;
            r_tmo   <= '0;
            r_state <= ST_WAIT_RDY;
          end
          ST_WAIT_RDY: begin
            // A data_ready inside the holdoff window may be the previous capture's level.
            if ((r_ho == HO_W'(HOLDOFF)) && data_ready) begin
              r_addr    <= w_win_start;
              rdaddress <= w_win_start;
              rden      <= 1'b1;
              r_rem     <= r_ns;
              r_state   <= ST_FETCH;
            end else if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
              timeout_err <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_tmo <= r_tmo + 1'b1;
              if (r_ho != HO_W'(HOLDOFF)) r_ho <= r_ho + 1'b1;
            end
          end
          ST_FETCH: begin
            rden    <= 1'b0;
            r_state <= ST_WAIT_DATA;
          end
          ST_WAIT_DATA: begin
            if (w_rd_vld) begin
              r_hold    <= rd_data;
              r_ch      <= w_first;
              out_data  <= rd_data[BYTE_W*int'(w_first) +: BYTE_W];
              out_valid <= 1'b1;
              r_state   <= ST_SEND;
            end
          end
          ST_SEND: begin
            if (out_ready) begin
`ifdef ACQ_READOUT_CSUM_EN
              r_csum <= r_csum ^ out_data;
`endif
              if (w_nxt[2]) begin
                r_ch     <= w_nxt[1:0];
                out_data <= r_hold[BYTE_W*int'(w_nxt[1:0]) +: BYTE_W];
              end else begin
                r_addr <= w_addr_inc;
                r_rem  <= w_rem_dec;
                if (w_rem_dec != '0) begin
                  out_valid <= 1'b0;
                  rden      <= 1'b1;
                  rdaddress <= w_addr_inc;
                  r_state   <= ST_FETCH;
                end else begin
`ifdef ACQ_READOUT_CSUM_EN
                  out_data   <= r_csum ^ out_data;
                  r_state    <= ST_CSUM;
`else
                  out_valid  <= 1'b0;
                  frame_done <= 1'b1;
                  r_state    <= ST_DONE;
`endif
                end
              end
            end
          end
`ifdef ACQ_READOUT_CSUM_EN
          ST_CSUM: begin
            if (out_ready) begin
              out_valid  <= 1'b0;
              frame_done <= 1'b1;
              r_state    <= ST_DONE;
            end
          end
`endif
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acq_readout_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_acq_readout_seq                                       |
// | Purpose  : Self-checking bench for acq_readout_seq with a RAM model |
// |            and a frame-level reference built from the window rules. |
// | Options  : ACQ_READOUT_CSUM_EN expects the trailing checksum byte.  |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_acq_readout_seq;

  localparam int RAM_W   = 10;
  localparam int RD_LAT  = 1;
  localparam int TMO     = 100;
  localparam int HOLDOFF = 2;
  localparam int DEPTH   = 1 << RAM_W;

  logic             clk;
  logic             rstn;
  logic             cmd_arm;
  logic             cmd_abort;
  logic [RAM_W-1:0] cfg_triggerpoint;
  logic [RAM_W:0]   cfg_nsamples;
  logic [3:0]       cfg_chmask;
  logic             start_trigger;
  logic             data_ready;
  logic [RAM_W-1:0] wraddress_triggerpoint;
  logic             rden;
  logic [RAM_W-1:0] rdaddress;
  logic [31:0]      rd_data;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             frame_done;
  logic             timeout_err;
  logic             cfg_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [DEPTH];
  logic [31:0] ram_q;

  acq_readout_seq #(
    .RAM_W       (RAM_W),
    .RD_LAT      (RD_LAT),
    .TIMEOUT_CYC (TMO),
    .HOLDOFF     (HOLDOFF)
  ) dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .cmd_arm                (cmd_arm),
    .cmd_abort              (cmd_abort),
    .cfg_triggerpoint       (cfg_triggerpoint),
    .cfg_nsamples           (cfg_nsamples),
    .cfg_chmask             (cfg_chmask),
    .start_trigger          (start_trigger),
    .data_ready             (data_ready),
    .wraddress_triggerpoint (wraddress_triggerpoint),
    .rden                   (rden),
    .rdaddress              (rdaddress),
    .rd_data                (rd_data),
    .out_data               (out_data),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .busy                   (busy),
    .frame_done             (frame_done),
    .timeout_err            (timeout_err),
    .cfg_err                (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency capture RAM.
  always @(posedge clk) if (rden) ram_q <= mem[rdaddress];
  assign rd_data = ram_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_st"},   start_trigger, 0);
    check({tag, "_rden"}, rden,          0);
    check({tag, "_addr"}, rdaddress,     0);
    check({tag, "_data"}, out_data,      0);
    check({tag, "_vld"},  out_valid,     0);
    check({tag, "_busy"}, busy,          0);
    check({tag, "_fd"},   frame_done,    0);
    check({tag, "_tmo"},  timeout_err,   0);
    check({tag, "_cfg"},  cfg_err,       0);
  endtask

  // Run one full frame and compare it against the expected window contents.
  task automatic run_frame(input logic [3:0] mask, input int n, input int tp,
                           input int wtp, input bit rand_rdy, input bit dr_early);
    logic [7:0]  exp_b[$];
    logic [7:0]  got_b[$];
    int          exp_a[$];
    int          got_a[$];
    logic [31:0] w;
    logic [7:0]  prev_d;
    int          cyc, st_cnt, st_cyc, fd_cnt;
    bit          prev_v, prev_r, first_rd;
`ifdef ACQ_READOUT_CSUM_EN
    logic [7:0]  x;
`endif
    for (int s = 0; s < n; s++) begin
      int a;
      a = (wtp - tp + s) & (DEPTH - 1);
      exp_a.push_back(a);
      w = mem[a];
      for (int c = 0; c < 4; c++) if (mask[c]) exp_b.push_back(w[8*c +: 8]);
    end
`ifdef ACQ_READOUT_CSUM_EN
    x = 8'h00;
    foreach (exp_b[i]) x ^= exp_b[i];
    exp_b.push_back(x);
`endif
    cfg_chmask = mask;
    cfg_nsamples = 11'(n);
    cfg_triggerpoint = 10'(tp);
    wraddress_triggerpoint = 10'(wtp);
    data_ready = dr_early;
    out_ready = 1'b0;
    cmd_arm = 1'b1;
    step();
    cmd_arm = 1'b0;
    cfg_chmask = 4'($urandom);
    cfg_nsamples = 11'($urandom);
    cfg_triggerpoint = 10'($urandom);
    check("arm_busy", busy, 1);
    check("arm_tmo_clr", timeout_err, 0);
    cyc = 0; st_cnt = 0; st_cyc = 0; fd_cnt = 0;
    prev_v = 0; prev_r = 1; prev_d = 0; first_rd = 1;
    while (cyc < 20000 && fd_cnt == 0) begin
      if (start_trigger) begin st_cnt++; st_cyc = cyc; end
      if (!dr_early && st_cnt > 0 && cyc == st_cyc + 7) data_ready = 1'b1;
      if (rden) begin
        got_a.push_back(int'(rdaddress));
        if (first_rd && dr_early) check("holdoff_lat", 64'(cyc - st_cyc), 64'(HOLDOFF + 2));
        first_rd = 0;
      end
      if (prev_v && !prev_r) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_d);
      end
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) got_b.push_back(out_data);
      if (frame_done) fd_cnt++;
      prev_v = out_valid; prev_r = out_ready; prev_d = out_data;
      step();
      cyc++;
    end
    check("frame_done_seen", 64'(fd_cnt), 1);
    check("start_pulses", 64'(st_cnt), 1);
    check("fd_one_cycle", frame_done, 0);
    check("idle_after", busy, 0);
    check("n_bytes", 64'(got_b.size()), 64'(exp_b.size()));
    check("n_reads", 64'(got_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      check($sformatf("byte%0d", i), got_b[i], exp_b[i]);
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      check($sformatf("addr%0d", i), 64'(got_a[i]), 64'(exp_a[i]));
    data_ready = 1'b0;
    out_ready = 1'b0;
    step();
  endtask

  initial begin
    int k;
    rstn = 1'b0; cmd_arm = 1'b0; cmd_abort = 1'b0;
    cfg_triggerpoint = '0; cfg_nsamples = '0; cfg_chmask = '0;
    data_ready = 1'b0; wraddress_triggerpoint = '0; out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    repeat (3) step();
    check_all_zero("reset");
    rstn = 1'b1;
    step();

    // Wrap at window start: addresses 1023,0,1,2.
    run_frame(4'b0001, 4, 2, 1, 1'b0, 1'b0);
    // Sparse mask with random back-pressure.
    run_frame(4'b1010, 3, int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH-1)), 1'b1, 1'b0);
    // data_ready already high before arm.
    run_frame(4'b0110, 5, 1000, 3, 1'b1, 1'b1);
    // Randomized frames.
    for (int r = 0; r < 4; r++)
      run_frame(4'($urandom_range(1, 15)), int'($urandom_range(1, 20)),
                int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH-1)),
                1'b1, 1'($urandom_range(0, 1)));
    // Full RAM window.
    run_frame(4'b0100, DEPTH, 5, 700, 1'b0, 1'b0);

    // Timeout with data_ready never asserted.
    cfg_chmask = 4'b0001; cfg_nsamples = 11'd1; data_ready = 1'b0;
    cmd_arm = 1'b1; step(); cmd_arm = 1'b0;
    repeat (90) step();
    check("tmo_not_yet", timeout_err, 0);
    check("tmo_busy", busy, 1);
    repeat (20) step();
    check("tmo_err", timeout_err, 1);
    check("tmo_idle", busy, 0);
    repeat (5) step();
    check("tmo_sticky", timeout_err, 1);
    run_frame(4'b1001, 2, 7, 9, 1'b0, 1'b0);
    check("tmo_cleared", timeout_err, 0);

    // Rejected arms.
    cfg_chmask = 4'b0000; cfg_nsamples = 11'd4;
    cmd_arm = 1'b1; step(); cmd_arm = 1'b0;
    check("cfgerr_mask", cfg_err, 1);
    check("cfgerr_mask_busy", busy, 0);
    check("cfgerr_mask_st", start_trigger, 0);
    step();
    check("cfgerr_pulse", cfg_err, 0);
    cfg_chmask = 4'b0001; cfg_nsamples = 11'd0;
    cmd_arm = 1'b1; step(); cmd_arm = 1'b0;
    check("cfgerr_n0", cfg_err, 1);
    check("cfgerr_n0_busy", busy, 0);
    cfg_nsamples = 11'(DEPTH + 1);
    cmd_arm = 1'b1; step(); cmd_arm = 1'b0;
    check("cfgerr_nbig", cfg_err, 1);
    check("cfgerr_nbig_st", start_trigger, 0);
    step();

    // Four channels, one sample of known content.
    mem[5] = 32'h01020408;
    run_frame(4'b1111, 1, 0, 5, 1'b0, 1'b0);

    // Abort while a byte is stalled.
    cfg_chmask = 4'b1111; cfg_nsamples = 11'd8; cfg_triggerpoint = 10'd0;
    wraddress_triggerpoint = 10'd100; out_ready = 1'b0; data_ready = 1'b1;
    cmd_arm = 1'b1; step(); cmd_arm = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin step(); k++; end
    check("abort_reach_send", out_valid, 1);
    cmd_abort = 1'b1; step(); cmd_abort = 1'b0;
    check("abort_vld", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_rden", rden, 0);
    data_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (frame_done) k++;
      step();
    end
    check("abort_no_fd", 64'(k), 0);

    // Arm and abort together in IDLE.
    cmd_arm = 1'b1; cmd_abort = 1'b1; step(); cmd_arm = 1'b0; cmd_abort = 1'b0;
    check("armabort_busy", busy, 0);
    check("armabort_st", start_trigger, 0);
    check("armabort_cfg", cfg_err, 0);
    step();

    // Reset in the middle of FETCH.
    cfg_chmask = 4'b0011; cfg_nsamples = 11'd4; wraddress_triggerpoint = 10'd50;
    data_ready = 1'b1;
    cmd_arm = 1'b1; step(); cmd_arm = 1'b0;
    k = 0;
    while (!rden && k < 50) begin step(); k++; end
    check("rst_reach_fetch", rden, 1);
    rstn = 1'b0; step();
    check_all_zero("midrst");
    rstn = 1'b1; data_ready = 1'b0; step();

    // Recovery frame after reset.
    run_frame(4'b1100, 3, 20, 10, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
